// File: rtl/pvr_arb_pkg.sv
// Shared types and constants for the PVR DDR read arbiter.
// Used by pvr_ddr_arbiter and pvr_rr_select (PVR_ARB_ROUND_ROBIN_EN selects round-robin).
package pvr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int ARB_ADDR_W = 29;
  localparam int ARB_DATA_W = 64;
  localparam int WD_W       = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pvr_rr_select.sv
// Grant selection: request vector plus last-grant pointer to one-hot grant and index.
// PVR_ARB_ROUND_ROBIN_EN defined: round-robin from ptr+1; undefined: lowest index wins.
module pvr_rr_select #(
  parameter int NUM_CLI = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_CLI-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_CLI-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

`ifdef PVR_ARB_ROUND_ROBIN_EN
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_CLI; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_CLI) j = j - NUM_CLI;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_CLI; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        idx    = IDX_W'(i);
        gnt[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/pvr_ddr_arbiter.sv
// Single-outstanding DDR read arbiter for the PVR read clients, with WAIT watchdog.
// Grant policy set by PVR_ARB_ROUND_ROBIN_EN (see pvr_rr_select).
module pvr_ddr_arbiter
  import pvr_arb_pkg::*;
#(
  parameter int NUM_CLI     = 3,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CLI-1:0]        cli_rd_req,
  input  logic [NUM_CLI*ADDR_W-1:0] cli_addr,
  output logic [NUM_CLI-1:0]        cli_valid,
  output logic [DATA_W-1:0]         cli_rdata,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic                      cache_rd,
  input  logic                      cache_valid,
  input  logic [DATA_W-1:0]         cache_rdata,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = idx_w(NUM_CLI);

  arb_state_t                      state, state_nx;
  logic [IDX_W-1:0]                grant, last_grant, sel_idx;
  logic [NUM_CLI-1:0]              sel_gnt, grant_oh;
  logic                            sel_any, wd_hit;
  logic [WD_W-1:0]                 wd_cnt;
  logic [NUM_CLI-1:0][ADDR_W-1:0]  addr_arr;

  assign addr_arr = cli_addr;
  assign grant_oh = NUM_CLI'(1) << grant;
  assign busy     = (state != IDLE);
  // Fires during the TIMEOUT_CYC-th WAIT cycle, so abort follows exactly that many WAIT cycles.
  assign wd_hit   = (TIMEOUT_CYC != 0) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  pvr_rr_select #(.NUM_CLI(NUM_CLI), .IDX_W(IDX_W)) u_sel (
    .req (cli_rd_req),
    .ptr (last_grant),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

  logic unused_gnt;
  assign unused_gnt = ^sel_gnt;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (sel_any) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (cache_valid || wd_hit) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant       <= '0;
      last_grant  <= IDX_W'(NUM_CLI - 1);
      cache_addr  <= '0;
      cache_rd    <= 1'b0;
      cli_valid   <= '0;
      cli_rdata   <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      cache_rd  <= 1'b0;
      cli_valid <= '0;
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant      <= sel_idx;
            cache_addr <= addr_arr[sel_idx];
            cache_rd   <= 1'b1;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A return in the final watchdog cycle still counts as a good read.
          if (cache_valid) begin
            cli_rdata  <= cache_rdata;
            cli_valid  <= grant_oh;
            last_grant <= grant;
          end else if (wd_hit) begin
            cli_rdata   <= '0;
            cli_valid   <= grant_oh;
            timeout_err <= 1'b1;
            last_grant  <= grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pvr_ddr_arbiter.sv
// Directed bench for pvr_ddr_arbiter: vector table of single reads plus corner-case sequences.
module tb_pvr_ddr_arbiter;

  localparam int NC = 3;
  localparam int AW = 29;
  localparam int DW = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic [NC-1:0]   cli_rd_req;
  logic [NC*AW-1:0] cli_addr;
  logic [NC-1:0]   cli_valid;
  logic [DW-1:0]   cli_rdata;
  logic [AW-1:0]   cache_addr;
  logic            cache_rd;
  logic            cache_valid;
  logic [DW-1:0]   cache_rdata;
  logic            busy;
  logic            timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pvr_ddr_arbiter #(.NUM_CLI(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .cli_rd_req  (cli_rd_req),
    .cli_addr    (cli_addr),
    .cli_valid   (cli_valid),
    .cli_rdata   (cli_rdata),
    .cache_addr  (cache_addr),
    .cache_rd    (cache_rd),
    .cache_valid (cache_valid),
    .cache_rdata (cache_rdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [NC-1:0]    req;
    logic [NC*AW-1:0] addr;
    int               lat;
    logic [DW-1:0]    data;
    int               exp;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NC*AW-1:0] mk(input logic [AW-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  // Steps until cache_rd is seen; returns cycles taken (0 if it never came).
  task automatic wait_rd(output int n);
    bit got;
    got = 0;
    n   = 0;
    for (int i = 1; i <= 10; i++) begin
      if (!got) begin
        tick();
        if (cache_rd) begin
          got = 1;
          n   = i;
        end
      end
    end
  endtask

  task automatic run_vec(input int v);
    int n;
    logic [NC*AW-1:0] a;
    a          = vecs[v].addr;
    cli_rd_req = vecs[v].req;
    cli_addr   = a;
    wait_rd(n);
    chk($sformatf("v%0d_rd_lat", v), n, 1);
    chk($sformatf("v%0d_addr", v), cache_addr, a[vecs[v].exp*AW +: AW]);
    tick();
    chk($sformatf("v%0d_rd_pulse", v), cache_rd, 0);
    for (int k = 1; k < vecs[v].lat; k++) tick();
    cache_valid = 1'b1;
    cache_rdata = vecs[v].data;
    tick();
    cache_valid = 1'b0;
    chk($sformatf("v%0d_valid", v), cli_valid, 3'b001 << vecs[v].exp);
    chk($sformatf("v%0d_rdata", v), cli_rdata, vecs[v].data);
    cli_rd_req[vecs[v].exp] = 1'b0;
    tick();
    chk($sformatf("v%0d_idle", v), {busy, cli_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic [NC*AW-1:0] a;

    vecs[0] = '{3'b010, mk(29'h0, 29'h0000100, 29'h0), 4, 64'hDEADBEEF_00000001, 1};
    vecs[1] = '{3'b111, mk(29'h10, 29'h20, 29'h30), 1, 64'h1111_0000_0000_0001, 0};
    vecs[2] = '{3'b111, mk(29'h10, 29'h20, 29'h30), 2, 64'h2222_0000_0000_0002, 0};
    vecs[3] = '{3'b111, mk(29'h10, 29'h20, 29'h30), 3, 64'h3333_0000_0000_0003, 0};
    vecs[4] = '{3'b111, mk(29'h10, 29'h20, 29'h30), 5, 64'h4444_0000_0000_0004, 0};
    vecs[5] = '{3'b111, mk(29'h10, 29'h20, 29'h30), 2, 64'h5555_0000_0000_0005, 0};
    vecs[6] = '{3'b111, mk(29'h10, 29'h20, 29'h30), 1, 64'h6666_0000_0000_0006, 0};
    vecs[7] = '{3'b110, mk(29'h40, 29'h1FFFFFFF, 29'h50), 2, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[8] = '{3'b100, mk(29'h0, 29'h0, 29'h0ABCDEF), 3, 64'h0123_4567_89AB_CDEF, 2};
`ifdef PVR_ARB_ROUND_ROBIN_EN
    // last_grant starts at 2; after vector 0 it is 1, so the all-request run rotates 2,0,1,...
    vecs[1].exp = 2; vecs[2].exp = 0; vecs[3].exp = 1;
    vecs[4].exp = 2; vecs[5].exp = 0; vecs[6].exp = 1;
    vecs[7].exp = 2;
`endif

    reset       = 1'b1;
    cli_rd_req  = '0;
    cli_addr    = '0;
    cache_valid = 1'b0;
    cache_rdata = '0;
    tick(); tick(); tick();
    chk("rst_outs", {cli_valid, cache_rd, busy, timeout_err}, 0);
    chk("rst_rdata", cli_rdata, 0);
    chk("rst_addr", cache_addr, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", {busy, cache_rd}, 0);

    // Stray cache_valid while idle must be dropped.
    cache_valid = 1'b1;
    cache_rdata = 64'hBAD0;
    tick();
    cache_valid = 1'b0;
    chk("stray_valid", {cli_valid, busy}, 0);
    chk("stray_rdata", cli_rdata, 0);

    for (int v = 0; v < 9; v++) run_vec(v);

    // Watchdog abort after 8 WAIT cycles; requests changing mid-flight must not move the grant.
    a          = mk(29'h77, 29'h0, 29'h0);
    cli_rd_req = 3'b001;
    cli_addr   = a;
    wait_rd(n);
    chk("to_rd_lat", n, 1);
    tick();
    for (int w = 1; w <= 8; w++) begin
      chk($sformatf("to_wait%0d", w), {cli_valid, timeout_err}, 0);
      if (w == 3) begin
        cli_rd_req = 3'b111;
        cli_addr   = mk(29'h99, 29'h98, 29'h97);
      end
      tick();
    end
    chk("to_valid", cli_valid, 3'b001);
    chk("to_rdata", cli_rdata, 0);
    chk("to_err", timeout_err, 1);
    chk("to_addr_held", cache_addr, 29'h77);
    cli_rd_req = '0;
    tick();
    chk("to_idle", {busy, cli_valid}, 0);
    chk("to_sticky", timeout_err, 1);

    // Client 0 holds its request through DONE: no re-issue until back in IDLE.
    cli_rd_req = 3'b001;
    cli_addr   = mk(29'h0A5, 29'h0, 29'h0);
    wait_rd(n);
    chk("hold_rd_lat", n, 1);
    tick();
    cache_valid = 1'b1;
    cache_rdata = 64'hCAFE_F00D_0000_0007;
    tick();
    cache_valid = 1'b0;
    chk("hold_valid", cli_valid, 3'b001);
    chk("hold_done_rd", cache_rd, 0);
    tick();
    chk("hold_idle_rd", {cache_rd, busy}, 0);
    tick();
    chk("hold_regrant", cache_rd, 1);
    chk("hold_regrant_addr", cache_addr, 29'h0A5);
    cli_rd_req = '0;
    tick();
    cache_valid = 1'b1;
    cache_rdata = 64'h8;
    tick();
    cache_valid = 1'b0;
    chk("hold_valid2", cli_valid, 3'b001);
    tick();
    chk("hold_idle2", {busy, cache_rd}, 0);

    // Reset during WAIT; late cache_valid must not produce cli_valid.
    cli_rd_req = 3'b010;
    cli_addr   = mk(29'h0, 29'h123, 29'h0);
    wait_rd(n);
    chk("rw_rd_lat", n, 1);
    tick();
    chk("rw_busy", busy, 1);
    reset      = 1'b1;
    cli_rd_req = '0;
    tick();
    reset = 1'b0;
    chk("rw_outs", {cli_valid, cache_rd, busy, timeout_err}, 0);
    chk("rw_rdata", cli_rdata, 0);
    chk("rw_addr", cache_addr, 0);
    cache_valid = 1'b1;
    cache_rdata = 64'h5A5A;
    tick();
    cache_valid = 1'b0;
    chk("rw_late_valid", {cli_valid, busy}, 0);
    chk("rw_late_rdata", cli_rdata, 0);
    tick();
    chk("rw_quiet", {cli_valid, busy, cache_rd}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pvr_ddr_arbiter.md
PVR_DDR_ARBITER -- requirements
Module: pvr_ddr_arbiter

Interface
REQ-001 Parameter: NUM_CLI, 3, number of PVR read clients (ISP params, TSP params, texture).
REQ-002 Parameter: ADDR_W, 29, DDR word-address width.
REQ-003 Parameter: DATA_W, 64, read-data width.
REQ-004 Parameter: TIMEOUT_CYC, 1024, max cycles in WAIT before abort; 0 disables the watchdog.
REQ-005 Single clock and reset; reset is synchronous and active-high; ports named clock and reset.
REQ-006 clock  in  1  sole clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cli_rd_req  in  NUM_CLI  per-client level request, held with stable address until that client's cli_valid.
REQ-009 cli_addr  in  NUM_CLI*ADDR_W  packed client word addresses; client i at bits [i*ADDR_W +: ADDR_W].
REQ-010 cli_valid  out  NUM_CLI  one-cycle pulse to the granted client when cli_rdata is valid.
REQ-011 cli_rdata  out  DATA_W  shared registered read data.
REQ-012 cache_addr  out  ADDR_W  word address to the downstream read cache.
REQ-013 cache_rd  out  1  one-cycle read strobe to the cache.
REQ-014 cache_valid  in  1  cache returns one word.
REQ-015 cache_rdata  in  DATA_W  cache read data.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 timeout_err  out  1  sticky watchdog-abort flag.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one read outstanding at any time.
REQ-019 IDLE: if any cli_rd_req bit is set, latch the grant index and its address into cache_addr, then go to ISSUE; otherwise remain in IDLE.
REQ-020 ISSUE: assert cache_rd for exactly one cycle with cache_addr stable, then go to WAIT.
REQ-021 WAIT: on cache_valid, register cache_rdata into cli_rdata, pulse cli_valid[grant] on the next cycle, and go to DONE.
REQ-022 DONE: ignore all requests for one cycle, then go to IDLE; this prevents re-granting a client whose request is still high.
REQ-023 Minimum latency: request seen in IDLE at cycle N, cache_rd at N+1, cli_valid at cycle M+1 where cache_valid is at M.
REQ-024 cache_valid outside WAIT is ignored.
REQ-025 Requests that change while busy do not alter the latched grant or address.
REQ-026 Watchdog: a 16-bit counter clears on WAIT entry and increments each WAIT cycle.
REQ-027 If the counter reaches TIMEOUT_CYC (nonzero): set timeout_err, pulse cli_valid[grant] with cli_rdata = 0, and go to DONE.
REQ-028 Grant pointer: last_grant is updated on DONE entry.

Reset
REQ-029 On reset: state=IDLE, cache_rd=0, cli_valid=0, cli_rdata=0, cache_addr=0, busy=0, timeout_err=0, counter=0, last_grant=NUM_CLI-1.
REQ-030 Reset mid-transaction abandons the request without issuing cli_valid; a late cache_valid after reset is dropped per REQ-024.

Configuration
REQ-031 Macro PVR_ARB_ROUND_ROBIN_EN defined: grant the first requesting client, searching upward from last_grant+1 modulo NUM_CLI.
REQ-032 Macro PVR_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; last_grant is unused.

Structure
REQ-033 Shared package pvr_arb_pkg holds the FSM state enum, default ADDR_W/DATA_W constants and the watchdog counter width.
REQ-034 Grant selection is the sub-module pvr_rr_select (combinational request vector plus pointer to one-hot grant and index); the macro applies inside it.

Verification
REQ-035 Single client 1 requests addr 0x0000100, cache_valid with 0xDEADBEEF_00000001 four cycles after cache_rd -> cache_rd once with cache_addr 0x0000100; cli_valid=3'b010 one cycle later with that data.
REQ-036 All three clients request continuously, with round-robin enabled -> grants in order 0,1,2,0,1,2; without the macro -> grants 0 each time client 0 re-requests.
REQ-037 Client 0 holds its request through DONE -> no duplicate cache_rd until client 0 re-requests after cli_valid.
REQ-038 TIMEOUT_CYC=8 and no cache_valid -> after 8 WAIT cycles timeout_err=1, cli_valid[grant] pulses with data 0, and the FSM returns to IDLE.
REQ-039 Reset asserted in WAIT, then cache_valid arrives after reset -> no cli_valid, state IDLE, all outputs at reset values.
